reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: drives NSTAGES staged active-high resets. After RST or a
// software request all outputs are held for HOLD_CYCLES, then released one
// stage at a time. Each stage waits for its own ACK bit, followed by
// STAGE_GAP idle cycles, before the next stage is released.
// Optional feature: define RESET_SEQ_TIMEOUT_EN to bound each ack wait to
// TIMEOUT cycles. An expired wait sets the sticky TIMEOUT_ERR flag and the
// sequence continues as if the ack had arrived.
module reset_sequencer #(
  parameter int NSTAGES     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_REQ,
  input  logic [NSTAGES-1:0] ACK,
  output logic [NSTAGES-1:0] OUT_RST,
  output logic               BUSY,
  output logic               SEQ_DONE,
  output logic               TIMEOUT_ERR
);

  // One shared down-counter serves the hold, gap and timeout phases.
  localparam int CNT_MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX    = (CNT_MAX_HG > TIMEOUT) ? CNT_MAX_HG : TIMEOUT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int STG_W      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NSTAGES - 1);
  localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STG_W-1:0]   stg_q, stg_d;
  logic [NSTAGES-1:0] out_rst_q, out_rst_d;
  logic               advance;
`ifdef RESET_SEQ_TIMEOUT_EN
  logic               err_q, err_d;
  logic               timed_out;
`endif

  // State register. RST is synchronous and overrides everything, including
  // any partial release already done.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_HOLD;
      cnt_q     <= CNT_HOLD;
      stg_q     <= '0;
      out_rst_q <= '1;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stg_q     <= stg_d;
      out_rst_q <= out_rst_d;
`ifdef RESET_SEQ_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  // Next-state logic: walk the stages, then let a software request restart
  // the whole sequence from HOLD.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stg_d     = stg_q;
    out_rst_d = out_rst_q;
    advance   = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
    err_d     = err_q;
    timed_out = 1'b0;
`endif

    case (state_q)
      ST_HOLD: begin
        if (cnt_q <= CNT_ONE) begin
          // Only reachable with HOLD_CYCLES == 1. Release stage 0 directly so
          // that it still falls on the first edge after entering HOLD.
          out_rst_d[0] = 1'b0;
          stg_d        = '0;
          cnt_d        = CNT_TO;
          state_d      = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_TWO) begin
            stg_d   = '0;
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        // The release is registered and becomes visible on leaving RELEASE.
        // The ack wait begins on the next cycle.
        out_rst_d[stg_q] = 1'b0;
        cnt_d            = CNT_TO;
        state_d          = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        advance = ACK[stg_q];
`ifdef RESET_SEQ_TIMEOUT_EN
        timed_out = !ACK[stg_q] && (cnt_q == CNT_ONE);
        if (timed_out) begin
          err_d   = 1'b1;
          advance = 1'b1;
        end else if (!advance) begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
        if (advance) begin
          if (stg_q == LAST_STG) begin
            state_d = ST_DONE;
          end else if (STAGE_GAP == 0) begin
            stg_d   = stg_q + STG_ONE;
            state_d = ST_RELEASE;
          end else begin
            cnt_d   = CNT_GAP;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (cnt_q <= CNT_ONE) begin
          stg_d   = stg_q + STG_ONE;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        // Unused encodings recover by restarting the sequence.
        out_rst_d = '1;
        cnt_d     = CNT_HOLD;
        stg_d     = '0;
        state_d   = ST_HOLD;
      end
    endcase

    // A software request restarts from HOLD in any state. It does not clear
    // the sticky timeout flag.
    if (SW_REQ) begin
      out_rst_d = '1;
      cnt_d     = CNT_HOLD;
      stg_d     = '0;
      state_d   = ST_HOLD;
    end
  end

  assign OUT_RST  = out_rst_q;
  assign BUSY     = (state_q != ST_DONE);
  assign SEQ_DONE = (state_q == ST_DONE);
`ifdef RESET_SEQ_TIMEOUT_EN
  assign TIMEOUT_ERR = err_q;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer. It drives two instances:
//   u_dut  - default timing (NSTAGES=4, HOLD=8, GAP=2)
//   u_gap0 - STAGE_GAP=0 and TIMEOUT=16
// A vector table covers the full default sequence, both after RST and after
// SW_REQ. Hand-written sequences cover the multi-cycle corner cases.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_req;
  logic [3:0] ack;

  logic [3:0] out_rst;
  logic       busy;
  logic       seq_done;
  logic       terr;

  logic [3:0] out_rst0;
  logic       busy0;
  logic       seq_done0;
  logic       terr0;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NSTAGES(4), .HOLD_CYCLES(8), .STAGE_GAP(2), .TIMEOUT(255)
  ) u_dut (
    .CLK(clk), .RST(rst), .SW_REQ(sw_req), .ACK(ack),
    .OUT_RST(out_rst), .BUSY(busy), .SEQ_DONE(seq_done), .TIMEOUT_ERR(terr)
  );

  reset_sequencer #(
    .NSTAGES(4), .HOLD_CYCLES(8), .STAGE_GAP(0), .TIMEOUT(16)
  ) u_gap0 (
    .CLK(clk), .RST(rst), .SW_REQ(sw_req), .ACK(ack),
    .OUT_RST(out_rst0), .BUSY(busy0), .SEQ_DONE(seq_done0), .TIMEOUT_ERR(terr0)
  );

  typedef struct {
    logic       rst;
    logic       sw;
    logic [3:0] ack;
    logic [3:0] out;    // u_dut OUT_RST
    logic       busy;   // u_dut BUSY
    logic       done;   // u_dut SEQ_DONE
    logic [3:0] out0;   // u_gap0 OUT_RST
    logic       done0;  // u_gap0 SEQ_DONE
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge. Outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  // Three RST cycles. The last RST edge is edge 0, the entry into HOLD.
  task automatic do_reset(input logic [3:0] a);
    ack    = a;
    sw_req = 1'b0;
    rst    = 1'b1;
    repeat (3) tick();
    rst    = 1'b0;
    edge_n = 0;
  endtask

  function automatic void add(input int n, input logic r, input logic s, input logic [3:0] a,
                              input logic [3:0] o, input logic b, input logic d,
                              input logic [3:0] o0, input logic d0);
    vec_t v;
    v.rst = r; v.sw = s; v.ack = a; v.out = o; v.busy = b; v.done = d;
    v.out0 = o0; v.done0 = d0;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // Edges 1..22 after entering HOLD, with ACK tied high.
  // u_dut releases at edges 8/12/16/20 and is done at 21.
  // u_gap0 releases at edges 8/10/12/14 and is done at 15.
  function automatic void add_std_seq();
    add(7, 0, 0, 4'hF, 4'hF, 1, 0, 4'hF, 0);  // edges 1-7
    add(2, 0, 0, 4'hF, 4'hE, 1, 0, 4'hE, 0);  // 8-9
    add(2, 0, 0, 4'hF, 4'hE, 1, 0, 4'hC, 0);  // 10-11
    add(2, 0, 0, 4'hF, 4'hC, 1, 0, 4'h8, 0);  // 12-13
    add(1, 0, 0, 4'hF, 4'hC, 1, 0, 4'h0, 0);  // 14
    add(1, 0, 0, 4'hF, 4'hC, 1, 0, 4'h0, 1);  // 15
    add(4, 0, 0, 4'hF, 4'h8, 1, 0, 4'h0, 1);  // 16-19
    add(1, 0, 0, 4'hF, 4'h0, 1, 0, 4'h0, 1);  // 20
    add(2, 0, 0, 4'hF, 4'h0, 0, 1, 4'h0, 1);  // 21-22
  endfunction

  initial begin
    rst    = 1'b1;
    sw_req = 1'b0;
    ack    = 4'hF;

    // ---- table: reset sequence, then a SW_REQ pulse in DONE ----
    add(3, 1, 0, 4'hF, 4'hF, 1, 0, 4'hF, 0);
    add_std_seq();
    add(1, 0, 1, 4'hF, 4'hF, 1, 0, 4'hF, 0);
    add_std_seq();

    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      sw_req = vecs[i].sw;
      ack    = vecs[i].ack;
      tick();
      check($sformatf("vec%0d_dut", i), {out_rst, busy, seq_done, terr},
            {vecs[i].out, vecs[i].busy, vecs[i].done, 1'b0});
      check($sformatf("vec%0d_gap0", i), {out_rst0, busy0, seq_done0, terr0},
            {vecs[i].out0, ~vecs[i].done0, vecs[i].done0, 1'b0});
    end
    rst    = 1'b0;
    sw_req = 1'b0;

    // ---- ACK[1] withheld for 50 cycles after the stage-1 release ----
    // ACK[2]/ACK[3] are high during the wait and must be ignored.
    do_reset(4'b1101);
    run_to(12);
    check("s1_released", out_rst, 4'hC);
    repeat (50) tick();
    check("ack1_wait_out", out_rst, 4'hC);
    check("ack1_wait_busy", busy, 1'b1);
    ack = 4'hF;
    tick();                                  // first edge that sees ACK[1]=1
    tick();
    tick();
    check("ack1_gap_hold", out_rst, 4'hC);
    tick();                                  // 3rd edge after the sampling edge
    check("ack1_rel2", out_rst, 4'h8);
    tick();                                  // stage 2 accepts ACK[2]
    ack = 4'b1000;                           // earlier acks drop from here on
    tick();
    tick();
    tick();
    check("rel3_out", {out_rst, busy}, {4'h0, 1'b1});
    tick();
    check("rel3_done", {out_rst, seq_done}, {4'h0, 1'b1});
    ack = 4'h0;
    repeat (3) tick();
    check("ack_drop_no_effect", {out_rst, seq_done}, {4'h0, 1'b1});

    // ---- SW_REQ held high keeps HOLD restarting ----
    ack    = 4'hF;
    sw_req = 1'b1;
    repeat (12) tick();
    check("sw_held", {out_rst, busy, seq_done}, {4'hF, 1'b1, 1'b0});
    sw_req = 1'b0;
    edge_n = 0;
    run_to(7);
    check("sw_held_hold7", out_rst, 4'hF);
    run_to(8);
    check("sw_held_rel8", out_rst, 4'hE);

    // ---- RST pulse during WAIT_ACK of stage 2 ----
    do_reset(4'b1011);
    run_to(20);
    check("s2_waiting", {out_rst, busy}, {4'h8, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_seq", {out_rst, busy, seq_done}, {4'hF, 1'b1, 1'b0});
    ack    = 4'hF;
    edge_n = 0;
    run_to(7);
    check("rst_restart_hold7", out_rst, 4'hF);
    run_to(8);
    check("rst_restart_rel8", out_rst, 4'hE);

    // ---- ACK[0] stuck low, observed on u_gap0 (TIMEOUT=16) ----
    do_reset(4'b1110);
`ifdef RESET_SEQ_TIMEOUT_EN
    run_to(23);
    check("to_before", {out_rst0, terr0}, {4'hE, 1'b0});
    run_to(24);                              // 16th WAIT_ACK cycle
    check("to_set", {out_rst0, terr0}, {4'hE, 1'b1});
    run_to(25);
    check("to_rel1", out_rst0, 4'hC);
    run_to(29);
    check("to_rel3", {out_rst0, busy0}, {4'h0, 1'b1});
    run_to(30);
    check("to_done", {seq_done0, terr0}, {1'b1, 1'b1});
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check("to_sticky_sw", {out_rst0, terr0}, {4'hF, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("to_cleared_rst", terr0, 1'b0);
`else
    run_to(60);
    check("noto_wait_gap0", {out_rst0, busy0, terr0}, {4'hE, 1'b1, 1'b0});
    check("noto_wait_dut", {out_rst, busy, terr}, {4'hE, 1'b1, 1'b0});
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
